// File: rtl/riscuin_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/grant/valid port, execute
// redirect, and the decoder-side valid/ready instruction stream.
// master = fetch unit side, slave = environment (memory, execute, decoder).
interface riscuin_fetch_unit_if #(
  parameter int unsigned INSTR_ADDR_WIDTH = 10
);
  // Instruction memory port
  logic                        imem_req;
  logic [INSTR_ADDR_WIDTH-1:0] imem_addr;
  logic                        imem_gnt;
  logic                        imem_valid;
  logic [31:0]                 imem_rdata;
  // Redirect from execute
  logic                        redirect;
  logic [INSTR_ADDR_WIDTH-1:0] redirect_pc;
  // Decoder stream
  logic                        instr_valid;
  logic                        instr_ready;
  logic [31:0]                 instr;
  logic [INSTR_ADDR_WIDTH-1:0] instr_pc;
  logic                        pc_end;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc_end,
    input  imem_gnt, imem_valid, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc_end,
    output imem_gnt, imem_valid, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/riscuin_fetch_unit.sv
// Instruction-fetch front end: single-outstanding request/grant/valid fetch
// port feeding a FIFO_DEPTH-entry prefetch FIFO of {instr, pc} pairs.
// A redirect flushes the FIFO and discards any response still in flight.
// Optional macro RISCUIN_FETCH_BYPASS_EN: when the FIFO is empty, a returning
// response is presented to the decoder in the same cycle (1-cycle latency).
module riscuin_fetch_unit #(
  parameter int unsigned                 INSTR_ADDR_WIDTH = 10,
  parameter int unsigned                 FIFO_DEPTH       = 4,
  parameter logic [INSTR_ADDR_WIDTH-1:0] RESET_PC         = '0,
  parameter logic [INSTR_ADDR_WIDTH-1:0] END_ADDR         = '1
) (
  input  logic                 clk,
  input  logic                 rst,
  riscuin_fetch_unit_if.master fetch_bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef logic [INSTR_ADDR_WIDTH-1:0] pc_t;

  typedef struct packed {
    logic [31:0] instr;
    pc_t         pc;
  } entry_t;

  // Fetch-side state
  pc_t        r_fetch_pc;
  pc_t        r_issued_pc;
  logic       r_outstanding;
  logic       r_drop;
  logic       r_stop;
  logic       r_pc_end;

  // Prefetch FIFO
  entry_t           r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [SUM_W-1:0] w_inflight;
  logic             w_credit_ok;
  logic             w_req;
  logic             w_xfer;
  logic             w_rsp;
  logic             w_rsp_keep;
  logic             w_fifo_empty;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic             w_fifo_pop;
  logic             w_instr_valid;
  logic [31:0]      w_instr;
  pc_t              w_instr_pc;

  // Credit: FIFO entries plus the in-flight request must fit in the FIFO,
  // so a response can always be pushed without checking for full.
  assign w_inflight  = SUM_W'(r_count) + SUM_W'(r_outstanding);
  assign w_credit_ok = (w_inflight < SUM_W'(FIFO_DEPTH));

  // A new request may overlap the cycle in which the current one returns.
  assign w_req = rst & ~r_stop & ~fetch_bus.redirect
               & (~r_outstanding | (fetch_bus.imem_valid & ~r_drop))
               & w_credit_ok;

  assign w_xfer       = w_req & fetch_bus.imem_gnt;
  assign w_rsp        = r_outstanding & fetch_bus.imem_valid;
  assign w_rsp_keep   = w_rsp & ~r_drop & ~fetch_bus.redirect;
  assign w_fifo_empty = (r_count == '0);

`ifdef RISCUIN_FETCH_BYPASS_EN
  assign w_bypass = w_rsp_keep & w_fifo_empty;
`else
  assign w_bypass = 1'b0;
`endif

  // Decoder-facing head: FIFO entry first, else the bypassed response.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_instr_valid = 1'b0;
    w_instr       = '0;
    w_instr_pc    = '0;
    if (!w_fifo_empty) begin
      w_instr_valid = 1'b1;
      w_instr       = r_mem[r_rd_ptr].instr;
      w_instr_pc    = r_mem[r_rd_ptr].pc;
    end else if (w_bypass) begin
      w_instr_valid = 1'b1;
      w_instr       = fetch_bus.imem_rdata;
      w_instr_pc    = r_issued_pc;
    end
  end

  // A pop in a redirect cycle is void; a bypassed word consumed by the
  // decoder never enters the FIFO.
  assign w_pop      = w_instr_valid & fetch_bus.instr_ready & ~fetch_bus.redirect;
  assign w_fifo_pop = w_pop & ~w_fifo_empty;
  assign w_push     = w_rsp_keep & ~(w_bypass & fetch_bus.instr_ready);

  assign fetch_bus.imem_req    = w_req;
  assign fetch_bus.imem_addr   = r_fetch_pc;
  assign fetch_bus.instr_valid = w_instr_valid;
  assign fetch_bus.instr       = w_instr;
  assign fetch_bus.instr_pc    = w_instr_pc;
  assign fetch_bus.pc_end      = r_pc_end;

  // Fetch PC, outstanding/drop tracking, end-of-program stop and pc_end flag.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_issued_pc   <= RESET_PC;
      r_outstanding <= 1'b0;
      r_drop        <= 1'b0;
      r_stop        <= 1'b0;
      r_pc_end      <= 1'b0;
    end else begin
      if (fetch_bus.redirect) begin
        r_fetch_pc <= fetch_bus.redirect_pc;
        r_stop     <= 1'b0;
      end else if (w_xfer) begin
        r_fetch_pc <= r_fetch_pc + 1'b1;
        if (r_fetch_pc == END_ADDR) begin
          r_stop <= 1'b1;
        end
      end

      if (w_xfer) begin
        r_outstanding <= 1'b1;
        r_issued_pc   <= r_fetch_pc;
      end else if (w_rsp) begin
        r_outstanding <= 1'b0;
      end

      if (fetch_bus.redirect && r_outstanding && !fetch_bus.imem_valid) begin
        r_drop <= 1'b1;
      end else if (w_rsp && r_drop) begin
        r_drop <= 1'b0;
      end

      if (fetch_bus.redirect) begin
        r_pc_end <= 1'b0;
      end else if (w_pop && (w_instr_pc == END_ADDR)) begin
        r_pc_end <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy; redirect empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst || fetch_bus.redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_fifo_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_fifo_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; r_count alone decides which entries are live.
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{instr: fetch_bus.imem_rdata, pc: r_issued_pc};
    end
  end

endmodule

// File: tb/tb_riscuin_fetch_unit.sv
// Self-checking bench for riscuin_fetch_unit. The reference model is the
// program-order instruction stream: after reset or redirect the decoder must
// see consecutive word addresses (wrapping) up to END_ADDR, each carrying the
// memory word for that address. A monitor pops and compares every handshake.
module tb_riscuin_fetch_unit;

  localparam int unsigned  W     = 10;
  localparam int unsigned  DEPTH = 4;
  localparam logic [W-1:0] RPC   = 10'h010;
  localparam logic [W-1:0] ENDA  = 10'h005;
`ifdef RISCUIN_FETCH_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  riscuin_fetch_unit_if #(.INSTR_ADDR_WIDTH(W)) bus ();

  riscuin_fetch_unit #(
    .INSTR_ADDR_WIDTH(W),
    .FIFO_DEPTH      (DEPTH),
    .RESET_PC        (RPC),
    .END_ADDR        (ENDA)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  // Scoreboard: pcs the decoder must still receive, in order
  logic [W-1:0] exp_q [$];

  // Memory model state (driver-owned)
  bit           mem_busy = 0;
  int           mem_wait = 0;
  logic [W-1:0] mem_addr = '0;
  int           gnt_pct  = 100;
  int           lat_min  = 1;
  int           lat_max  = 1;

  // Monitor-side model and statistics
  logic [W-1:0] exp_fetch   = '0;
  bit           exp_stop    = 0;
  bit           exp_pc_end  = 0;
  bit           prev_rst_low = 0;
  bit           prev_wait   = 0;
  logic [W-1:0] prev_addr   = '0;
  bit           post_redir  = 0;
  logic [W-1:0] post_pc     = '0;
  bit           lat_arm     = 0;
  int           gnt_cyc     = -1;
  int           iv_cyc      = -1;
  int           rel_cyc     = -1;
  int           grant_cnt   = 0;
  int           pop_cnt     = 0;

  function automatic logic [31:0] word(input logic [W-1:0] a);
    return 32'h00A0_0093 + 32'(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Expected delivery order from a start address up to END_ADDR, with wrap.
  task automatic load_stream(input logic [W-1:0] start);
    logic [W-1:0] pc;
    exp_q.delete();
    pc = start;
    for (int i = 0; i < (1 << W); i++) begin
      exp_q.push_back(pc);
      if (pc == ENDA) break;
      pc = pc + 1'b1;
    end
  endtask

  // One clock cycle of stimulus plus the memory model.
  task automatic step(input bit do_rst, input bit do_redir, input logic [W-1:0] rpc, input bit rdy);
    @(posedge clk);
    #1;
    bus.imem_valid = 1'b0;
    if (mem_busy) begin
      mem_wait--;
      if (mem_wait <= 0) begin
        bus.imem_valid = 1'b1;
        bus.imem_rdata = word(mem_addr);
        mem_busy       = 0;
      end
    end
    rst             = !do_rst;
    bus.redirect    = do_redir;
    bus.redirect_pc = rpc;
    if (do_rst) load_stream(RPC);
    else if (do_redir) load_stream(rpc);
    bus.instr_ready = rdy;
    bus.imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
    @(negedge clk);
    if (rst && bus.imem_req && bus.imem_gnt) begin
      mem_busy = 1;
      mem_wait = $urandom_range(lat_min, lat_max);
      mem_addr = bus.imem_addr;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1, 0, '0, 1);
  endtask

  task automatic arm();
    gnt_cyc   = -1;
    iv_cyc    = -1;
    grant_cnt = 0;
    pop_cnt   = 0;
    lat_arm   = 1;
  endtask

  // Monitor: samples each cycle's events at the falling edge.
  initial begin
    logic [W-1:0] pc;
    forever begin
      @(negedge clk);
      cycle++;
      if (!rst) begin
        check("req_in_reset", 64'(bus.imem_req), 64'd0);
        if (prev_rst_low) begin
          check("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
          check("rst_instr", 64'(bus.instr), 64'd0);
          check("rst_instr_pc", 64'(bus.instr_pc), 64'd0);
          check("rst_imem_addr", 64'(bus.imem_addr), 64'(RPC));
          check("rst_pc_end", 64'(bus.pc_end), 64'd0);
        end
        exp_fetch    = RPC;
        exp_stop     = 0;
        exp_pc_end   = 0;
        prev_wait    = 0;
        post_redir   = 0;
        prev_rst_low = 1;
      end else begin
        if (prev_rst_low) rel_cyc = cycle;
        prev_rst_low = 0;
        check("pc_end", 64'(bus.pc_end), 64'(exp_pc_end));
        if (bus.redirect) begin
          check("req_in_redirect", 64'(bus.imem_req), 64'd0);
          exp_fetch  = bus.redirect_pc;
          exp_stop   = 0;
          exp_pc_end = 0;
          prev_wait  = 0;
          post_redir = 1;
          post_pc    = bus.redirect_pc;
        end else begin
          if (post_redir) begin
            check("empty_after_redirect", 64'(bus.instr_valid), 64'd0);
            check("addr_after_redirect", 64'(bus.imem_addr), 64'(post_pc));
            post_redir = 0;
          end
          if (prev_wait) begin
            check("req_held", 64'(bus.imem_req), 64'd1);
            check("addr_held", 64'(bus.imem_addr), 64'(prev_addr));
          end
          if (exp_stop) check("req_after_end", 64'(bus.imem_req), 64'd0);
          if (bus.imem_req && bus.imem_gnt) begin
            check("fetch_addr", 64'(bus.imem_addr), 64'(exp_fetch));
            if (exp_fetch == ENDA) exp_stop = 1;
            exp_fetch = exp_fetch + 1'b1;
            grant_cnt++;
            if (lat_arm && gnt_cyc < 0) gnt_cyc = cycle;
          end
          if (lat_arm && iv_cyc < 0 && bus.instr_valid) iv_cyc = cycle;
          if (bus.instr_valid && bus.instr_ready) begin
            pop_cnt++;
            check("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
              pc = exp_q.pop_front();
              check("instr_pc", 64'(bus.instr_pc), 64'(pc));
              check("instr", 64'(bus.instr), 64'(word(pc)));
              if (pc == ENDA) exp_pc_end = 1;
            end
          end
          prev_wait = bus.imem_req && !bus.imem_gnt;
          prev_addr = bus.imem_addr;
        end
      end
    end
  end

  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_valid  = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b0;

    // Reset, 1-cycle memory, decoder always ready: latency and throughput
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset(3);
    arm();
    for (int i = 0; i < 8; i++) step(0, 0, '0, 1);
    check("first_grant_at_release", 64'(gnt_cyc), 64'(rel_cyc));
    check("grant_to_instr_valid", 64'(iv_cyc - gnt_cyc), 64'(EXP_LAT));
    check("back_to_back_pops", 64'(pop_cnt), 64'(8 - EXP_LAT));
    lat_arm = 0;

    // Decoder stalled: FIFO fills to DEPTH, no request while full
    do_reset(3);
    arm();
    for (int i = 0; i < 10; i++) step(0, 0, '0, 0);
    check("grants_while_stalled", 64'(grant_cnt), 64'(DEPTH));
    check("req_when_full", 64'(bus.imem_req), 64'd0);
    lat_arm = 0;
    for (int i = 0; i < 12; i++) step(0, 0, '0, 1);

    // Slow memory: redirect while 0x020 is in flight drops its response
    lat_min = 3; lat_max = 3;
    step(0, 1, 10'h020, 1);
    for (int i = 0; i < 10 && !(mem_busy && mem_addr == 10'h020); i++) step(0, 0, '0, 1);
    check("outstanding_020", 64'(mem_busy && mem_addr == 10'h020), 64'd1);
    step(0, 1, 10'h100, 1);
    for (int i = 0; i < 20; i++) step(0, 0, '0, 1);

    // End of program: stop after END_ADDR, pc_end, then restart
    lat_min = 1; lat_max = 1;
    step(0, 1, 10'h000, 1);
    for (int i = 0; i < 30; i++) step(0, 0, '0, 1);
    check("stream_done_at_end", 64'(exp_q.size()), 64'd0);
    check("pc_end_set", 64'(bus.pc_end), 64'd1);
    check("no_req_after_end", 64'(bus.imem_req), 64'd0);
    step(0, 1, 10'h000, 1);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1);
    check("pc_end_cleared", 64'(bus.pc_end), 64'd0);
    for (int i = 0; i < 20; i++) step(0, 0, '0, 1);

    // Redirect in a cycle with both a pop and a push
    step(0, 1, 10'h040, 1);
    for (int i = 0; i < 6; i++) step(0, 0, '0, 1);
    step(0, 1, 10'h080, 1);
    check("pop_push_in_redirect", 64'(bus.instr_valid && bus.imem_valid), 64'd1);
    for (int i = 0; i < 10; i++) step(0, 0, '0, 1);

    // Wrap-around from all-ones to zero
    step(0, 1, 10'h3FD, 1);
    for (int i = 0; i < 20; i++) step(0, 0, '0, 1);

    // Randomized traffic: grants, latencies, stalls, redirects, resets
    gnt_pct = 70; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      bit rdy;
      logic [W-1:0] rpc;
      r   = $urandom_range(0, 199);
      rdy = ($urandom_range(0, 3) != 0);
      if (r < 2) begin
        do_reset(4);
      end else if (r < 8) begin
        if ($urandom_range(0, 1) == 0) rpc = W'($urandom_range(0, (1 << W) - 1));
        else rpc = ENDA - W'($urandom_range(0, 12));
        step(0, 1, rpc, rdy);
      end else begin
        step(0, 0, '0, rdy);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscuin_fetch_unit.md
Name: riscuin_fetch_unit

Overview:
Parametrised instruction-fetch front end for the next RISCuinho core generation. It replaces direct PC-indexed program memory reads with a request/grant/valid fetch port and a prefetch FIFO of depth FIFO_DEPTH. The decoder pulls {instr, pc} pairs from the FIFO over a valid/ready handshake. Branch/jump redirects from execute flush the FIFO and discard any in-flight response.

Parameters:
INSTR_ADDR_WIDTH, 10, word-address width of the PC (byte address = {pc,2'b00})
FIFO_DEPTH, 4, prefetch entries; power of two, >= 2
RESET_PC, 0, word address fetched first after reset
END_ADDR, {INSTR_ADDR_WIDTH{1'b1}}, word address of the last program instruction

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
imem_req  out  1  fetch request
imem_addr  out  INSTR_ADDR_WIDTH  word address of the request
imem_gnt  in  1  request accepted this cycle
imem_valid  in  1  response valid; responses return in order, >=1 cycle after grant
imem_rdata  in  32  instruction word
redirect  in  1  flush and restart fetch
redirect_pc  in  INSTR_ADDR_WIDTH  restart word address
instr_valid  out  1  FIFO head valid
instr_ready  in  1  decoder accepts head
instr  out  32  head instruction
instr_pc  out  INSTR_ADDR_WIDTH  head word address
pc_end  out  1  sticky: the END_ADDR instruction was delivered

Behaviour:
- Reset (rst=0 at a clock edge): fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop=0, stop=0, pc_end=0. Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- At most 1 outstanding request. Transfer occurs when imem_req & imem_gnt.
- imem_req is combinational: rst & !stop & !redirect & (!outstanding | (imem_valid & !drop)) & (count + outstanding < FIFO_DEPTH). count and outstanding are registered values. imem_addr = fetch_pc.
- imem_req stays asserted with a stable imem_addr until granted, unless redirect occurs.
- On transfer: outstanding=1, fetch_pc+1 (mod 2^INSTR_ADDR_WIDTH). If imem_addr==END_ADDR, set stop=1 and issue no further requests.
- On imem_valid with outstanding=1:
  - drop=0: push {imem_rdata, issued pc} into the FIFO.
  - drop=1: discard the response and clear drop.
  - In both cases outstanding clears, unless a new transfer happens in the same cycle.
- imem_valid with outstanding=0 is a protocol error and is ignored.
- Pop when instr_valid & instr_ready. Push and pop in the same cycle leave count unchanged. No push ever occurs while full (guaranteed by the credit check).
- Latency, no bypass: grant at T, valid at T+1, instr_valid at T+2. Sustained throughput is 1 instruction/cycle with a 1-cycle memory.
- Redirect has priority over all other events in its cycle:
  - FIFO cleared; any pop that cycle is void.
  - fetch_pc=redirect_pc; stop=0; pc_end=0.
  - If outstanding and imem_valid is not present that cycle, drop=1.
  - imem_req=0 that cycle. Fetch resumes the next cycle, or once the dropped response has returned.
- pc_end is set on the cycle after popping the entry whose pc==END_ADDR. Once set, it holds until redirect or reset.
- Wrap-around: fetch_pc wraps from all-ones to 0 when END_ADDR is elsewhere.
- Reset mid-transfer: the in-flight response is ignored. Memory must accept that a response may arrive after reset.

Optional Feature:
RISCUIN_FETCH_BYPASS_EN
- Defined:
  - When the FIFO is empty and a non-dropped response arrives, instr_valid/instr/instr_pc are driven combinationally from imem_rdata in that same cycle.
  - If instr_ready=1, the word is consumed without a push. Otherwise it is pushed normally.
  - Latency: grant T -> instr_valid T+1.
- Undefined: all responses pass through the FIFO; latency is 2 cycles as above.

Test Plan:
- Reset with RESET_PC=0x010, memory returning word=0x00A00093+addr, 1-cycle latency, instr_ready=1 -> instrs for pcs 0x010,0x011,0x012 appear back-to-back from cycle 2 after reset release; imem_addr never repeats.
- instr_ready=0 for 10 cycles, FIFO_DEPTH=4 -> exactly 4 entries plus 0 outstanding, imem_req=0; on release 0x010..0x013 are drained in order, then fetch restarts at 0x014.
- Memory latency 3 cycles, redirect to 0x100 while a request to 0x020 is outstanding -> the 0x020 response is dropped; the first delivered instr_pc=0x100; no entry below 0x100 is delivered.
- END_ADDR=0x005, RESET_PC=0 -> no request beyond addr 0x005; pc_end=1 the cycle after 0x005 is popped; a following redirect to 0x000 clears pc_end and fetch resumes.
- Redirect in the same cycle as a pop and push -> the FIFO is empty the next cycle, the popped data is not counted, and imem_addr=redirect_pc.
- With RISCUIN_FETCH_BYPASS_EN and an empty FIFO -> grant at T gives instr_valid at T+1 with instr=imem_rdata. Without the macro -> T+2.
